// File: rtl/tl45_fetch.sv
// tl45 instruction fetch: single-outstanding Wishbone B4 pipelined reader feeding decode's buf_pc/buf_inst.
// Optional performance counters are enabled with `define TL45_FETCH_PERF_EN.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 30
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pipe_stall,
  input  logic                  i_pipe_flush,
  input  logic [31:0]           i_flush_pc,
  output logic [31:0]           o_buf_pc,
  output logic [31:0]           o_buf_inst,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  input  logic [31:0]           i_wb_data,
  output logic                  o_fetch_err
`ifdef TL45_FETCH_PERF_EN
  ,
  output logic [31:0]           o_perf_fetched,
  output logic [31:0]           o_perf_wait_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_HALT} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic [31:0] w_flush_pc;
  logic        w_deliver;
  logic        w_from_skid;
  logic        w_capture;

  assign w_flush_pc = i_flush_pc & ~32'h3;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Flush is folded in last so it overrides every state decision, including a coincident ack/err.
  always_comb begin
    w_next      = r_state;
    w_deliver   = 1'b0;
    w_from_skid = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:  w_next = S_ISSUE;
      S_ISSUE: if (!i_wb_stall) w_next = S_WAIT;
      S_WAIT: begin
        if (i_wb_err) begin
          w_next = S_HALT;
        end else if (i_wb_ack) begin
          if (!i_pipe_stall) begin
            w_deliver = 1'b1;
            w_next    = S_ISSUE;
          end else begin
            w_capture = 1'b1;
            w_next    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!i_pipe_stall) begin
          w_deliver   = 1'b1;
          w_from_skid = 1'b1;
          w_next      = S_ISSUE;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    if (i_pipe_flush) begin
      w_next      = S_IDLE;
      w_deliver   = 1'b0;
      w_from_skid = 1'b0;
      w_capture   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_pc  <= RESET_PC_ALIGNED;
      r_buf_pc    <= '0;
      r_buf_inst  <= '0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else if (i_pipe_flush) begin
      r_fetch_pc  <= w_flush_pc;
      r_buf_pc    <= '0;
      r_buf_inst  <= '0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else begin
      if (w_deliver) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_capture) begin
        r_skid_pc   <= r_fetch_pc;
        r_skid_inst <= i_wb_data;
      end
      // A stalled decode keeps its word; otherwise present the new word or a bubble.
      if (!i_pipe_stall) begin
        if (w_deliver && w_from_skid) begin
          r_buf_pc   <= r_skid_pc;
          r_buf_inst <= r_skid_inst;
        end else if (w_deliver) begin
          r_buf_pc   <= r_fetch_pc;
          r_buf_inst <= i_wb_data;
        end else begin
          r_buf_pc   <= '0;
          r_buf_inst <= '0;
        end
      end
    end
  end

  assign o_buf_pc    = r_buf_pc;
  assign o_buf_inst  = r_buf_inst;
  assign o_wb_cyc    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_wb_stb    = (r_state == S_ISSUE);
  assign o_wb_we     = 1'b0;
  assign o_wb_addr   = r_fetch_pc[ADDR_WIDTH+1:2];
  assign o_fetch_err = (r_state == S_HALT);

`ifdef TL45_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_wait;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_fetched <= '0;
      r_perf_wait    <= '0;
    end else begin
      if (w_deliver) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((r_state == S_ISSUE) || (r_state == S_WAIT)) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign o_perf_fetched     = r_perf_fetched;
  assign o_perf_wait_cycles = r_perf_wait;
`endif

endmodule

// File: tb/tb_tl45_fetch.sv
// Bench for tl45_fetch: directed cycle table, then random bus/pipeline traffic against a delivery-order model.
module tb_tl45_fetch;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_pipe_stall;
  logic        i_pipe_flush;
  logic [31:0] i_flush_pc;
  logic [31:0] o_buf_pc;
  logic [31:0] o_buf_inst;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [29:0] o_wb_addr;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_data;
  logic        o_fetch_err;
`ifdef TL45_FETCH_PERF_EN
  logic [31:0] perf_f;
  logic [31:0] perf_w;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tl45_fetch #(.RESET_PC(32'h0000_0100), .ADDR_WIDTH(30)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
    .i_flush_pc(i_flush_pc), .o_buf_pc(o_buf_pc), .o_buf_inst(o_buf_inst), .o_wb_cyc(o_wb_cyc),
    .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data), .o_fetch_err(o_fetch_err)
`ifdef TL45_FETCH_PERF_EN
    , .o_perf_fetched(perf_f), .o_perf_wait_cycles(perf_w)
`endif
  );

  typedef struct {
    logic        wst, ack, err, pst, fl;
    logic [31:0] fpc, dat;
    logic        cyc, stb;
    logic [29:0] adr;
    logic [31:0] bpc, binst;
    logic        ferr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wst, input logic ack, input logic err, input logic pst,
                              input logic fl, input logic [31:0] fpc, input logic [31:0] dat,
                              input logic cyc, input logic stb, input logic [29:0] adr,
                              input logic [31:0] bpc, input logic [31:0] binst, input logic ferr);
    vec_t v;
    v.wst = wst; v.ack = ack; v.err = err; v.pst = pst; v.fl = fl; v.fpc = fpc; v.dat = dat;
    v.cyc = cyc; v.stb = stb; v.adr = adr; v.bpc = bpc; v.binst = binst; v.ferr = ferr;
    return v;
  endfunction

  // Memory image seen by the random-phase slave; low bits set so a real word is never all-zero.
  function automatic logic [31:0] mem(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_pipe_stall = 1'b0; i_pipe_flush = 1'b0; i_flush_pc = '0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " cyc"},   32'(o_wb_cyc), 32'd0);
    chk({tag, " stb"},   32'(o_wb_stb), 32'd0);
    chk({tag, " addr"},  32'(o_wb_addr), 32'h40);
    chk({tag, " bufpc"}, o_buf_pc, 32'd0);
    chk({tag, " inst"},  o_buf_inst, 32'd0);
    chk({tag, " err"},   32'(o_fetch_err), 32'd0);
  endtask

  logic        stb_now, pend, have_word;
  logic [29:0] addr_now, pend_addr;
  logic [31:0] model_pc, prev_pc, prev_inst;
  int          wcnt, delivered;

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    chk("we", 32'(o_wb_we), 32'd0);

    //        wst ack err pst fl  fpc           dat            cyc stb adr           bpc           binst        ferr
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h40,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h40,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,        32'h0800_0001, 1,1, 30'h41,      32'h100,      32'h0800_0001,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h41,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,        32'h1111_0000, 1,1, 30'h42,      32'h104,      32'h1111_0000,0));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h42,      32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h42,      32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h42,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h42,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,        32'h2222_0000, 1,1, 30'h43,      32'h108,      32'h2222_0000,0));
    tbl.push_back(mk(0,0,0,1,0, 32'h0,        32'h0,         1,0, 30'h43,      32'h108,      32'h2222_0000,0));
    tbl.push_back(mk(0,1,0,1,0, 32'h0,        32'h1234_5678, 0,0, 30'h43,      32'h108,      32'h2222_0000,0));
    tbl.push_back(mk(0,0,0,1,0, 32'h0,        32'h0,         0,0, 30'h43,      32'h108,      32'h2222_0000,0));
    tbl.push_back(mk(0,0,0,1,0, 32'h0,        32'h0,         0,0, 30'h43,      32'h108,      32'h2222_0000,0));
    tbl.push_back(mk(0,0,0,1,0, 32'h0,        32'h0,         0,0, 30'h43,      32'h108,      32'h2222_0000,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h44,      32'h10C,      32'h1234_5678,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h44,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,1,0,0, 32'h0,        32'h3333_0000, 0,0, 30'h44,      32'h0,        32'h0,        1));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         0,0, 30'h44,      32'h0,        32'h0,        1));
    tbl.push_back(mk(0,0,0,0,1, 32'hFFFF_FFFF,32'h0,         0,0, 30'h3FFF_FFFF,32'h0,       32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h3FFF_FFFF,32'h0,       32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h3FFF_FFFF,32'h0,       32'h0,        0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,        32'h4444_0001, 1,1, 30'h0,       32'hFFFF_FFFC,32'h4444_0001,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h0,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,        32'h5555_0001, 1,1, 30'h1,       32'h0,        32'h5555_0001,0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h1,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,0,0,1, 32'h203,      32'hDEAD_BEEF, 0,0, 30'h80,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h80,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h80,      32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,        32'h6666_0001, 1,1, 30'h81,      32'h200,      32'h6666_0001,0));
    tbl.push_back(mk(0,0,0,1,1, 32'h10,       32'h0,         0,0, 30'h4,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h4,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h4,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,1,0,0, 32'h0,        32'h0,         0,0, 30'h4,       32'h0,        32'h0,        1));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         0,0, 30'h4,       32'h0,        32'h0,        1));
    tbl.push_back(mk(0,0,0,0,1, 32'h0,        32'h0,         0,0, 30'h0,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,1, 30'h0,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,        32'h0,         1,0, 30'h0,       32'h0,        32'h0,        0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0,        32'h7777_0001, 1,1, 30'h1,       32'h0,        32'h7777_0001,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      i_reset      = 1'b0;
      i_wb_stall   = tbl[i].wst;
      i_wb_ack     = tbl[i].ack;
      i_wb_err     = tbl[i].err;
      i_pipe_stall = tbl[i].pst;
      i_pipe_flush = tbl[i].fl;
      i_flush_pc   = tbl[i].fpc;
      i_wb_data    = tbl[i].dat;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d cyc", i),   32'(o_wb_cyc),    32'(tbl[i].cyc));
      chk($sformatf("row%0d stb", i),   32'(o_wb_stb),    32'(tbl[i].stb));
      chk($sformatf("row%0d addr", i),  32'(o_wb_addr),   32'(tbl[i].adr));
      chk($sformatf("row%0d bufpc", i), o_buf_pc,         tbl[i].bpc);
      chk($sformatf("row%0d inst", i),  o_buf_inst,       tbl[i].binst);
      chk($sformatf("row%0d ferr", i),  32'(o_fetch_err), 32'(tbl[i].ferr));
    end

    // Reset asserted mid-fetch with a coincident ack must win over everything.
    @(negedge clk);
    idle_inputs();
    i_reset   = 1'b1;
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    check_reset_state("midreset");

    model_pc  = 32'h100;
    pend      = 1'b0;
    pend_addr = '0;
    have_word = 1'b0;
    wcnt      = 0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      i_reset   = 1'b0;
      stb_now   = o_wb_stb;
      addr_now  = o_wb_addr;
      prev_pc   = o_buf_pc;
      prev_inst = o_buf_inst;
      if (stb_now) chk("stb_while_outstanding", 32'(pend), 32'd0);
      i_wb_stall   = ($urandom_range(0, 3) == 0);
      i_pipe_stall = ($urandom_range(0, 9) < 3);
      i_pipe_flush = ($urandom_range(0, 99) == 0);
      i_flush_pc   = $urandom;
      i_wb_err     = 1'b0;
      i_wb_ack     = pend && (wcnt == 0);
      i_wb_data    = i_wb_ack ? mem(pend_addr) : $urandom;
      @(posedge clk);
      #1;
      if (i_pipe_flush) begin
        pend      = 1'b0;
        have_word = 1'b0;
        model_pc  = i_flush_pc & ~32'h3;
        chk("rnd_flush_pc", o_buf_pc, 32'd0);
        chk("rnd_flush_inst", o_buf_inst, 32'd0);
      end else begin
        if (i_wb_ack) begin
          pend      = 1'b0;
          have_word = 1'b1;
        end else if (pend && wcnt > 0) begin
          wcnt--;
        end
        if (stb_now && !i_wb_stall) begin
          chk("rnd_req_addr", 32'(addr_now), 32'(model_pc[31:2]));
          chk("rnd_req_before_delivery", 32'(have_word), 32'd0);
          pend      = 1'b1;
          pend_addr = addr_now;
          wcnt      = $urandom_range(0, 2);
        end
        if (i_pipe_stall) begin
          chk("rnd_hold_pc", o_buf_pc, prev_pc);
          chk("rnd_hold_inst", o_buf_inst, prev_inst);
        end else if (have_word) begin
          chk("rnd_deliver_pc", o_buf_pc, model_pc);
          chk("rnd_deliver_inst", o_buf_inst, mem(model_pc[31:2]));
          model_pc  = model_pc + 32'd4;
          have_word = 1'b0;
          delivered++;
        end else begin
          chk("rnd_bubble_pc", o_buf_pc, 32'd0);
          chk("rnd_bubble_inst", o_buf_inst, 32'd0);
        end
      end
    end
    chk("rnd_progress", 32'(delivered > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
